// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Write side of the 9-bit instruction memory. Instructions arrive one per
//   handshake as opcode/field-A/field-B, are packed into {op,a,b}, and are
//   buffered in a small FIFO. From there they drain to sequential memory
//   addresses, starting at the session's StartAddr.
//
// Ports
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   Start, StartAddr    open a session (IDLE only) at StartAddr
//   InValid/InReady     instruction handshake
//   InOp, InA, InB      instruction fields, packed into word[8:6]/[5:3]/[2:0]
//   InLast              marks the final instruction of the session
//   MemWrEn, MemAddr,
//   MemData             registered instruction-memory write port
//   Busy                high in every state except IDLE
//   Done                one-cycle pulse at the end of a session
//   Overflow            sticky: a word (or Ack) fell beyond the top address
//   ReservedErr         sticky: 9'h1FF was presented without InLast
//
// Configuration
//   ACK_APPEND_EN  when defined, the Ack word 9'h1FF is written at the next
//                  address after the last instruction (TERM state).
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        InOp,
  input  logic [2:0]        InA,
  input  logic [2:0]        InB,
  input  logic              InLast,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [8:0]        MemData,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic              ReservedErr
);

  localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
  localparam logic [8:0]        ACK_WORD  = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
`ifdef ACK_APPEND_EN
    ST_TERM = 2'd2,
`endif
    ST_FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              exhausted_q, exhausted_d;
  logic              last_seen_q, last_seen_d;
  logic              overflow_q, overflow_d;
  logic              reserved_q, reserved_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [8:0]        fifo_mem_q [FIFO_DEPTH];
  logic [8:0]        fifo_mem_d [FIFO_DEPTH];
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [8:0]        mem_data_q, mem_data_d;

  logic       in_ready;
  logic       accept;
  logic       push;
  logic       pop;
  logic       flush;
  logic       wr_req;
  logic [8:0] wr_word;
  logic [8:0] in_word;
  logic       is_reserved;
  logic       fifo_full;

  assign in_word     = {InOp, InA, InB};
  assign is_reserved = (in_word == ACK_WORD) && !InLast;
  assign fifo_full   = (count_q == DEPTH_CNT);

  // Next-state, FIFO bookkeeping and the single memory write per cycle.
  // Once the top address has been written, "exhausted" stops the address
  // from advancing; the next word to reach the write port raises Overflow,
  // empties the FIFO and from then on input is swallowed until InLast.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    exhausted_d = exhausted_q;
    last_seen_d = last_seen_q;
    overflow_d  = overflow_q;
    reserved_d  = reserved_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_mem_d  = fifo_mem_q;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    wr_req      = 1'b0;
    wr_word     = '0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          addr_d      = StartAddr;
          exhausted_d = 1'b0;
          last_seen_d = 1'b0;
          overflow_d  = 1'b0;
          reserved_d  = 1'b0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // After an overflow the FIFO is bypassed, so fullness no longer matters.
        in_ready = overflow_q ? !last_seen_q : (!fifo_full && !last_seen_q);
        accept   = InValid && in_ready;
        if (accept && is_reserved) reserved_d = 1'b1;
        if (accept && InLast)      last_seen_d = 1'b1;
        pop   = (count_q != '0);
        flush = pop && exhausted_q;
        push  = accept && !is_reserved && !overflow_q && !flush;
        if (pop) begin
          wr_req  = 1'b1;
          wr_word = fifo_mem_q[rd_ptr_q];
        end
        if (last_seen_q && (count_q == '0)) begin
`ifdef ACK_APPEND_EN
          wr_req  = 1'b1;
          wr_word = ACK_WORD;
          state_d = ST_TERM;
`else
          state_d = ST_FIN;
`endif
        end
      end
`ifdef ACK_APPEND_EN
      ST_TERM: state_d = ST_FIN;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_mem_d[wr_ptr_q] = in_word;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (wr_req) begin
      if (exhausted_q) begin
        overflow_d = 1'b1;
      end else begin
        mem_wr_en_d = 1'b1;
        mem_addr_d  = addr_q;
        mem_data_d  = wr_word;
        if (addr_q == TOP_ADDR) exhausted_d = 1'b1;
        else                    addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      exhausted_q <= 1'b0;
      last_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
      reserved_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_mem_q  <= '{default: '0};
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      exhausted_q <= exhausted_d;
      last_seen_q <= last_seen_d;
      overflow_q  <= overflow_d;
      reserved_q  <= reserved_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_mem_q  <= fifo_mem_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign InReady     = in_ready;
  assign MemWrEn     = mem_wr_en_q;
  assign MemAddr     = mem_addr_q;
  assign MemData     = mem_data_q;
  assign Busy        = (state_q != ST_IDLE);
  assign Done        = (state_q == ST_FIN);
  assign Overflow    = overflow_q;
  assign ReservedErr = reserved_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Self-checking bench for instr_loader. A session-level model turns every
//   accepted instruction into the list of (address, word) writes it must
//   produce; a compare process matches every MemWrEn cycle against that list.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int TOP    = (1 << ADDR_W) - 1;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic [ADDR_W-1:0] StartAddr;
  logic              InValid;
  logic              InReady;
  logic [2:0]        InOp;
  logic [2:0]        InA;
  logic [2:0]        InB;
  logic              InLast;
  logic              MemWrEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [8:0]        MemData;
  logic              Busy;
  logic              Done;
  logic              Overflow;
  logic              ReservedErr;

  instr_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .InValid(InValid), .InReady(InReady), .InOp(InOp), .InA(InA), .InB(InB),
    .InLast(InLast), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemData(MemData),
    .Busy(Busy), .Done(Done), .Overflow(Overflow), .ReservedErr(ReservedErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  // Behavioural model state for the current session.
  logic [ADDR_W+8:0] expQ[$];
  int                modelAddr;
  bit                modelExhausted;
  bit                modelOverflow;
  bit                modelReserved;

  // Log of writes observed during the current session.
  logic [ADDR_W-1:0] logAddr[$];
  logic [8:0]        logData[$];
  int                firstWr;
  int                lastWr;
  int                doneCount;
  bit                checkEn = 1'b0;
  logic [ADDR_W+8:0] cmpEntry;
  logic [8:0]        wordsQ[$];
  int                stalls;

  always @(posedge Clk) cycle++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // A word either lands at the next address or, past the top, flags overflow.
  function automatic void modelWrite(input logic [8:0] w);
    logic [ADDR_W-1:0] a;
    if (modelExhausted) begin
      modelOverflow = 1'b1;
    end else begin
      a = modelAddr[ADDR_W-1:0];
      expQ.push_back({a, w});
      if (modelAddr == TOP) modelExhausted = 1'b1;
      else modelAddr++;
    end
  endfunction

  function automatic void modelAccept(input logic [8:0] w, input bit last);
    if (w == 9'h1FF && !last) modelReserved = 1'b1;
    else if (!modelOverflow)  modelWrite(w);
  endfunction

  function automatic void modelFinish();
`ifdef ACK_APPEND_EN
    modelWrite(9'h1FF);
`endif
  endfunction

  // Every memory write must match the head of the model's expected list.
  always @(negedge Clk) begin
    if (Reset && checkEn) begin
      if (MemWrEn) begin
        logAddr.push_back(MemAddr);
        logData.push_back(MemData);
        if (firstWr < 0) firstWr = cycle;
        lastWr = cycle;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWrite", 1, 0);
        end else begin
          cmpEntry = expQ.pop_front();
          checkOutput("memAddr", int'(MemAddr), int'(cmpEntry[ADDR_W+8:9]));
          checkOutput("memData", int'(MemData), int'(cmpEntry[8:0]));
        end
      end
      if (Done) doneCount++;
    end
  end

  task automatic startSession(input logic [ADDR_W-1:0] addr);
    expQ.delete();
    logAddr.delete();
    logData.delete();
    modelAddr      = int'(addr);
    modelExhausted = 1'b0;
    modelOverflow  = 1'b0;
    modelReserved  = 1'b0;
    firstWr        = -1;
    lastWr         = -1;
    doneCount      = 0;
    @(negedge Clk);
    Start     = 1'b1;
    StartAddr = addr;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [8:0] w, input bit last, input int maxGap,
                               input bit pulseStart, output int nStall);
    int gap;
    gap    = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    nStall = 0;
    repeat (gap) begin
      @(negedge Clk);
      InValid = 1'b0;
      Start   = 1'b0;
    end
    for (int t = 0; t < 100; t++) begin
      @(negedge Clk);
      Start = pulseStart && (t == 0);
      if (pulseStart && (t == 0)) StartAddr = ADDR_W'($urandom);
      InValid        = 1'b1;
      {InOp, InA, InB} = w;
      InLast         = last;
      #1;
      if (InReady) begin
        modelAccept(w, last);
        return;
      end
      nStall++;
    end
    checkOutput("inReadyTimeout", 0, 1);
  endtask

  task automatic finishSession();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge Clk);
      InValid = 1'b0;
      InLast  = 1'b0;
      Start   = 1'b0;
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("doneSeen", int'(seen), 1);
    @(negedge Clk);
    checkOutput("donePulseWidth", int'(Done), 0);
    checkOutput("busyAfterDone", int'(Busy), 0);
    checkOutput("pendingWrites", expQ.size(), 0);
    checkOutput("overflowFlag", int'(Overflow), int'(modelOverflow));
    checkOutput("reservedFlag", int'(ReservedErr), int'(modelReserved));
    checkOutput("doneCount", doneCount, 1);
  endtask

  task automatic runSession(input logic [ADDR_W-1:0] addr, input int maxGap,
                            input int pulseAt, output int totalStalls);
    int s;
    totalStalls = 0;
    startSession(addr);
    for (int i = 0; i < wordsQ.size(); i++) begin
      applyStimulus(wordsQ[i], i == wordsQ.size() - 1, maxGap, i == pulseAt, s);
      totalStalls += s;
    end
    modelFinish();
    finishSession();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "InReady"}, int'(InReady), 0);
    checkOutput({tag, "MemWrEn"}, int'(MemWrEn), 0);
    checkOutput({tag, "MemAddr"}, int'(MemAddr), 0);
    checkOutput({tag, "MemData"}, int'(MemData), 0);
    checkOutput({tag, "Busy"}, int'(Busy), 0);
    checkOutput({tag, "Done"}, int'(Done), 0);
    checkOutput({tag, "Overflow"}, int'(Overflow), 0);
    checkOutput({tag, "ReservedErr"}, int'(ReservedErr), 0);
  endtask

`ifdef ACK_APPEND_EN
  localparam int ACK_EXTRA = 1;
`else
  localparam int ACK_EXTRA = 0;
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    int n;
    int pulseAt;
    logic [ADDR_W-1:0] sa;
    logic [8:0] w;

    Reset = 1'b0; Start = 1'b0; StartAddr = '0; InValid = 1'b0;
    InOp = '0; InA = '0; InB = '0; InLast = 1'b0;
    #1;
    checkResetOutputs("reset_");
    @(negedge Clk);
    @(negedge Clk);
    Reset   = 1'b1;
    checkEn = 1'b1;

    // Three-instruction program at 0x010.
    wordsQ = '{9'b000_010_001, 9'b001_011_010, 9'b010_000_111};
    runSession(10'h010, 0, -1, s);
    checkOutput("basicWriteCount", logAddr.size(), 3 + ACK_EXTRA);
    checkOutput("basicAddr0", int'(logAddr[0]), 'h010);
    checkOutput("basicData0", int'(logData[0]), 'h011);
    checkOutput("basicData1", int'(logData[1]), 'h05A);
    checkOutput("basicAddr2", int'(logAddr[2]), 'h012);
    checkOutput("basicData2", int'(logData[2]), 'h087);
`ifdef ACK_APPEND_EN
    checkOutput("basicAckAddr", int'(logAddr[3]), 'h013);
    checkOutput("basicAckData", int'(logData[3]), 'h1FF);
`endif

    // Back-to-back stream of 8 words: full throughput, contiguous, in order.
    wordsQ.delete();
    for (int i = 0; i < 8; i++) wordsQ.push_back(9'(i * 37 + 5));
    runSession(10'h040, 0, -1, s);
    checkOutput("streamStalls", s, 0);
    checkOutput("streamWriteCount", logAddr.size(), 8 + ACK_EXTRA);
    checkOutput("streamSpan", lastWr - firstWr, 7 + ACK_EXTRA);
    for (int i = 0; i < logAddr.size() && i < 8; i++)
      checkOutput("streamAddr", int'(logAddr[i]), 'h040 + i);

    // Crossing the top of memory.
    wordsQ = '{9'h00A, 9'h00B, 9'h00C, 9'h00D};
    runSession(ADDR_W'(TOP - 1), 0, -1, s);
    checkOutput("ovfWriteCount", logAddr.size(), 2);
    checkOutput("ovfAddr0", int'(logAddr[0]), TOP - 1);
    checkOutput("ovfAddr1", int'(logAddr[1]), TOP);
    checkOutput("ovfFlag", int'(Overflow), 1);

    // Reserved pattern in the middle of a program.
    wordsQ = '{9'h021, 9'h1FF, 9'h063};
    runSession(10'h200, 0, -1, s);
    checkOutput("rsvWriteCount", logAddr.size(), 2 + ACK_EXTRA);
    checkOutput("rsvAddr1", int'(logAddr[1]), 'h201);
    checkOutput("rsvData1", int'(logData[1]), 'h063);
    checkOutput("rsvFlag", int'(ReservedErr), 1);
    startSession(10'h210);
    checkOutput("rsvClearedByStart", int'(ReservedErr), 0);
    applyStimulus(9'h1FF, 1'b1, 0, 1'b0, s);
    modelFinish();
    finishSession();
    checkOutput("lastAckWritten", int'(logData[0]), 'h1FF);

    // Start pulsed mid-session is ignored.
    wordsQ = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105};
    runSession(10'h300, 0, 2, s);
    checkOutput("ignStartAddr4", int'(logAddr[4]), 'h304);

    // Reset in the middle of a session with words still queued.
    startSession(10'h100);
    applyStimulus(9'h0AA, 1'b0, 0, 1'b0, s);
    applyStimulus(9'h0BB, 1'b0, 0, 1'b0, s);
    @(negedge Clk);
    InValid = 1'b0;
    Reset   = 1'b0;
    #1;
    checkResetOutputs("midReset_");
    expQ.delete();
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("noDoneAfterReset", int'(Done), 0);
      checkOutput("idleAfterReset", int'(Busy), 0);
    end
    wordsQ = '{9'h0CC, 9'h0DD};
    runSession(10'h120, 0, -1, s);
    checkOutput("postResetAddr0", int'(logAddr[0]), 'h120);

    // Randomized sessions, some near the top of memory.
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(10, 1));
      wordsQ.delete();
      for (int i = 0; i < n; i++) begin
        w = 9'($urandom);
        if ($urandom_range(5, 0) == 0) w = 9'h1FF;
        wordsQ.push_back(w);
      end
      if ($urandom_range(3, 0) == 0) sa = ADDR_W'(TOP - int'($urandom_range(5, 0)));
      else                          sa = ADDR_W'($urandom);
      pulseAt = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      runSession(sa, int'($urandom_range(2, 0)), pulseAt, s);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
